// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data-cache controller.
// Contents:
//    - address geometry: ADDR_W, OFF_W, IDX_W, derived TAG_W, LINE_W, word select width
//    - state_t : controller FSM states
//    - addr_tag / addr_idx / addr_word : field extraction from a byte address
//    - line_addr : rebuilds a line-aligned byte address from tag and index
package dcache_pkg;

   localparam int ADDR_W = 32;
   localparam int OFF_W  = 5;
   localparam int IDX_W  = 4;
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LINE_W = 256;
   localparam int WORD_W = 32;
   localparam int LINES  = 2 ** IDX_W;
   localparam int WSEL_W = OFF_W - 2;

   typedef enum logic [2:0] {
      IDLE,
      MISS,
      WRITEBACK,
      READMISS,
      READMISSOK
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
      return addr[OFF_W +: IDX_W];
   endfunction

   // Word within the line; the two byte bits are ignored (word-aligned accesses).
   function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
      return addr[2 +: WSEL_W];
   endfunction

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the direct-mapped cache: tag, valid, dirty and line data arrays.
// Reads are asynchronous on idx; writes happen on the rising clock edge.
// rst_i (async, active-high) clears valid, dirty and tags; line data is left as is
// because it is unreachable while its valid bit is clear.
// Ports:
//    clk_i, rst_i           clock, asynchronous active-high reset
//    idx                    set addressed by both read and write
//    rd_tag/valid/dirty/line  contents of set idx
//    word_we, word_sel, word_data   store of one 32-bit word, marks the set dirty
//    fill_we, fill_tag, fill_line   whole-line refill, marks the set valid and clean
module dcache_sram
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [IDX_W-1:0]  idx,
   output logic [TAG_W-1:0]  rd_tag,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [LINE_W-1:0] rd_line,
   input  logic              word_we,
   input  logic [WSEL_W-1:0] word_sel,
   input  logic [WORD_W-1:0] word_data,
   input  logic              fill_we,
   input  logic [TAG_W-1:0]  fill_tag,
   input  logic [LINE_W-1:0] fill_line
);

   logic [TAG_W-1:0]  tags  [LINES];
   logic [LINE_W-1:0] lines [LINES];
   logic [LINES-1:0]  valid;
   logic [LINES-1:0]  dirty;

   assign rd_tag   = tags[idx];
   assign rd_valid = valid[idx];
   assign rd_dirty = dirty[idx];
   assign rd_line  = lines[idx];

   // Metadata: a refill always wins over a store; the controller never asserts both.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid <= '0;
         dirty <= '0;
         for (int i = 0; i < LINES; i++) begin
            tags[i] <= '0;
         end
      end else if (fill_we) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
         tags[idx]  <= fill_tag;
      end else if (word_we) begin
         dirty[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill_we) begin
         lines[idx] <= fill_line;
      end else if (word_we) begin
         lines[idx][word_sel*WORD_W +: WORD_W] <= word_data;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data-cache controller between the
// MEM stage and off-chip memory. Hits complete with no stall; misses write back a
// dirty victim if needed, refill the line, then let the held access hit.
// Ports:
//    clk_i, rst_i            clock, asynchronous active-high reset (aborts any miss)
//    cpu_req_i, cpu_we_i     access request, 1 = store
//    cpu_addr_i, cpu_data_i  word-aligned byte address, store data
//    cpu_data_o              load data, valid when cpu_req_i && !cpu_stall_o
//    cpu_stall_o             access not complete, hold the pipeline
//    mem_enable_o, mem_write_o, mem_addr_o, mem_data_o   line request to memory
//    mem_data_i, mem_ack_i   refill data and one-cycle completion pulse
// Optional (macro DCACHE_STATS_EN): hit_cnt_o, miss_cnt_o access counters.
module dcache_ctrl
   import dcache_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [WORD_W-1:0] cpu_data_i,
   output logic [WORD_W-1:0] cpu_data_o,
   output logic              cpu_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   state_t state;
   state_t state_next;

   logic [TAG_W-1:0]  miss_tag;
   logic [IDX_W-1:0]  miss_idx;
   logic [IDX_W-1:0]  sram_idx;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid;
   logic              rd_dirty;
   logic [LINE_W-1:0] rd_line;
   logic              hit;
   logic              idle_hit;
   logic              start_miss;
   logic              fill_we;

   // While idle the array is addressed by the CPU; during a miss it stays on the
   // latched set so the victim and refill are unaffected by the CPU dropping its request.
   assign sram_idx   = (state == IDLE) ? addr_idx(cpu_addr_i) : miss_idx;
   assign hit        = cpu_req_i && rd_valid && (rd_tag == addr_tag(cpu_addr_i));
   assign idle_hit   = (state == IDLE) && hit;
   assign start_miss = (state == IDLE) && cpu_req_i && !hit;
   assign fill_we    = (state == READMISS) && mem_ack_i;

   assign cpu_data_o  = idle_hit ? rd_line[addr_word(cpu_addr_i)*WORD_W +: WORD_W] : '0;
   assign cpu_stall_o = (state != IDLE) || (cpu_req_i && !hit);

   dcache_sram u_sram (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .idx       (sram_idx),
      .rd_tag    (rd_tag),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_line   (rd_line),
      .word_we   (idle_hit && cpu_we_i),
      .word_sel  (addr_word(cpu_addr_i)),
      .word_data (cpu_data_i),
      .fill_we   (fill_we),
      .fill_tag  (miss_tag),
      .fill_line (mem_data_i)
   );

   // State register plus the address of the access being serviced.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         miss_tag <= '0;
         miss_idx <= '0;
      end else begin
         state <= state_next;
         if (start_miss) begin
            miss_tag <= addr_tag(cpu_addr_i);
            miss_idx <= addr_idx(cpu_addr_i);
         end
      end
   end

   // Next state and memory interface. Request outputs are decoded from the state
   // alone, so they hold steady through the ack cycle and drop right after it.
   always_comb begin
      state_next   = state;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      unique case (state)
         IDLE: begin
            if (start_miss) state_next = MISS;
         end
         MISS: begin
            state_next = (rd_valid && rd_dirty) ? WRITEBACK : READMISS;
         end
         WRITEBACK: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = line_addr(rd_tag, miss_idx);
            mem_data_o   = rd_line;
            if (mem_ack_i) state_next = READMISS;
         end
         READMISS: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = line_addr(miss_tag, miss_idx);
            if (mem_ack_i) state_next = READMISSOK;
         end
         READMISSOK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic refilled;

   // The hit that completes a just-refilled access is not counted as a hit;
   // refilled marks that first idle cycle after READMISSOK.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
         refilled   <= 1'b0;
      end else begin
         refilled <= (state == READMISSOK);
         if (idle_hit && !refilled) hit_cnt_o <= hit_cnt_o + 32'd1;
         if (start_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl. A responder plays off-chip memory with a
// programmable latency; a line-level cache model predicts hits, write-backs,
// refills, stall lengths and load data. Stats checks compile only with DCACHE_STATS_EN.
module tb_dcache_ctrl;

   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [255:0] data;
   } txn_t;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         cpu_req_i = 1'b0;
   logic         cpu_we_i = 1'b0;
   logic [31:0]  cpu_addr_i = '0;
   logic [31:0]  cpu_data_i = '0;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt_o;
   logic [31:0]  miss_cnt_o;
`endif

   int checks = 0;
   int errors = 0;
   int mem_lat = 10;

   logic [255:0] mem  [logic [31:0]];
   logic [255:0] gmem [logic [31:0]];
   txn_t txq[$];

   bit           mv [16];
   bit           md [16];
   logic [22:0]  mt [16];
   logic [255:0] ml [16];
   int m_hits = 0;
   int m_misses = 0;

   dcache_ctrl dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_req_i    (cpu_req_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_data_o   (cpu_data_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_ack_i    (mem_ack_i)
`ifdef DCACHE_STATS_EN
      ,
      .hit_cnt_o    (hit_cnt_o),
      .miss_cnt_o   (miss_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Power-on contents of a memory line, derived from its address.
   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) begin
         l[i*32 +: 32] = (a + 32'(i * 4)) ^ 32'h5A3C_0000 ^ (32'(i) << 24);
      end
      return l;
   endfunction

   // Memory responder: acks on the mem_lat-th cycle a request is held.
   initial begin
      int   cnt;
      txn_t t;
      cnt = 0;
      mem_ack_i = 1'b0;
      mem_data_i = '0;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (mem_enable_o) begin
            cnt++;
            if (cnt >= mem_lat) begin
               cnt = 0;
               mem_ack_i = 1'b1;
               t.we = mem_write_o;
               t.addr = mem_addr_o;
               if (mem_write_o) begin
                  t.data = mem_data_o;
                  mem[mem_addr_o] = mem_data_o;
               end else begin
                  t.data = mem.exists(mem_addr_o) ? mem[mem_addr_o] : init_line(mem_addr_o);
                  mem_data_i = t.data;
               end
               txq.push_back(t);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < 16; i++) begin
         mv[i] = 1'b0;
         md[i] = 1'b0;
      end
      m_hits = 0;
      m_misses = 0;
   endtask

   // One CPU access held until the DUT stops stalling, checked against the model.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
      logic [3:0]   idx;
      logic [22:0]  tag;
      logic [2:0]   w;
      logic [31:0]  la;
      logic [31:0]  victim;
      logic [31:0]  exp_word;
      logic [31:0]  got_word;
      txn_t         exp_q[$];
      int           exp_stall;
      int           stalls;
      bit           done;
      idx = addr[8:5];
      tag = addr[31:9];
      w   = addr[4:2];
      exp_stall = 0;
      if (mv[idx] && mt[idx] == tag) begin
         m_hits++;
      end else begin
         m_misses++;
         exp_stall = 3 + mem_lat;
         if (mv[idx] && md[idx]) begin
            victim = {mt[idx], idx, 5'b0};
            exp_q.push_back('{1'b1, victim, ml[idx]});
            gmem[victim] = ml[idx];
            exp_stall += mem_lat;
         end
         la = {tag, idx, 5'b0};
         ml[idx] = gmem.exists(la) ? gmem[la] : init_line(la);
         exp_q.push_back('{1'b0, la, ml[idx]});
         mv[idx] = 1'b1;
         mt[idx] = tag;
         md[idx] = 1'b0;
      end
      exp_word = ml[idx][w*32 +: 32];
      if (we) begin
         ml[idx][w*32 +: 32] = data;
         md[idx] = 1'b1;
      end

      txq.delete();
      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = data;
      stalls = 0;
      done = 1'b0;
      got_word = '0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk_i);
         if (!cpu_stall_o) begin
            done = 1'b1;
            got_word = cpu_data_o;
         end else begin
            stalls++;
         end
      end
      checkOutput("access_done", 256'(done), 256'(1));
      checkOutput("stall_cycles", 256'(stalls), 256'(exp_stall));
      if (!we) checkOutput("load_data", 256'(got_word), 256'(exp_word));
      checkOutput("txn_count", 256'(txq.size()), 256'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
         checkOutput("txn_write", 256'(txq[i].we), 256'(exp_q[i].we));
         checkOutput("txn_addr", 256'(txq[i].addr), 256'(exp_q[i].addr));
         if (exp_q[i].we) checkOutput("txn_wb_data", txq[i].data, exp_q[i].data);
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [31:0] wb_word1;
      logic [31:0] wb_addr;
      logic [31:0] a;
      bit          seen;
      resetModel();

      // Reset values while rst_i is high.
      #12;
      checkOutput("rst_stall", 256'(cpu_stall_o), 256'(0));
      checkOutput("rst_enable", 256'(mem_enable_o), 256'(0));
      checkOutput("rst_write", 256'(mem_write_o), 256'(0));
      checkOutput("rst_addr", 256'(mem_addr_o), 256'(0));
      checkOutput("rst_mem_data", mem_data_o, 256'(0));
      checkOutput("rst_cpu_data", 256'(cpu_data_o), 256'(0));
`ifdef DCACHE_STATS_EN
      checkOutput("rst_hit_cnt", 256'(hit_cnt_o), 256'(0));
      checkOutput("rst_miss_cnt", 256'(miss_cnt_o), 256'(0));
`endif
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Cold load with 10-cycle memory: 13 stall cycles, refill read at 0x40.
      mem_lat = 10;
      applyStimulus(1'b0, 32'h0000_0040, 32'h0);
`ifdef DCACHE_STATS_EN
      checkOutput("cold_miss_cnt", 256'(miss_cnt_o), 256'(1));
`endif

      // Store hit then load hit on the same line.
      applyStimulus(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0000_0044, 32'h0);

      // Dirty conflict: write-back of the 0x40 line carrying the stored word.
      applyStimulus(1'b0, 32'h0000_0240, 32'h0);
      wb_word1 = (txq.size() > 0) ? txq[0].data[63:32] : 32'h0;
      wb_addr  = (txq.size() > 0) ? txq[0].addr : 32'h0;
      checkOutput("wb_addr", 256'(wb_addr), 256'(32'h40));
      checkOutput("wb_word1", 256'(wb_word1), 256'(32'hDEAD_BEEF));

      // Clean conflict: straight refill, no write-back.
      applyStimulus(1'b0, 32'h0000_0080, 32'h0);
      applyStimulus(1'b0, 32'h0000_0280, 32'h0);

      // Reset while a refill is outstanding.
      mem_lat = 50;
      cpu_req_i = 1'b1;
      cpu_we_i = 1'b0;
      cpu_addr_i = 32'h0000_0040;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk_i);
         if (mem_enable_o && !mem_write_o) seen = 1'b1;
      end
      checkOutput("readmiss_seen", 256'(seen), 256'(1));
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      cpu_req_i = 1'b0;
      #1;
      checkOutput("abort_enable", 256'(mem_enable_o), 256'(0));
      checkOutput("abort_addr", 256'(mem_addr_o), 256'(0));
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      resetModel();
      mem_lat = 10;
      @(posedge clk_i);
      #1;

      // After reset 0x40 misses again; then 3 hits and a second miss.
      applyStimulus(1'b0, 32'h0000_0040, 32'h0);
      applyStimulus(1'b0, 32'h0000_0044, 32'h0);
      applyStimulus(1'b0, 32'h0000_0048, 32'h0);
      applyStimulus(1'b1, 32'h0000_004C, 32'h1234_5678);
      applyStimulus(1'b0, 32'h0000_0080, 32'h0);
`ifdef DCACHE_STATS_EN
      checkOutput("stats_hit_cnt", 256'(hit_cnt_o), 256'(3));
      checkOutput("stats_miss_cnt", 256'(miss_cnt_o), 256'(2));
`endif

      // Random loads/stores over a few tags and sets to force conflicts.
      for (int n = 0; n < 120; n++) begin
         mem_lat = $urandom_range(1, 6);
         a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
           | (32'($urandom_range(0, 7)) << 2);
         applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
      end
      cpu_req_i = 1'b0;
`ifdef DCACHE_STATS_EN
      checkOutput("final_hit_cnt", 256'(hit_cnt_o), 256'(m_hits));
      checkOutput("final_miss_cnt", 256'(miss_cnt_o), 256'(m_misses));
`endif
      @(posedge clk_i);
      #1;
      checkOutput("idle_enable", 256'(mem_enable_o), 256'(0));
      checkOutput("idle_stall", 256'(cpu_stall_o), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
